// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer and the control decoder:
// sequencer states, compare/jump opcodes and the jump-condition rule.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] OP_CMP = 4'b1001;
  localparam logic [3:0] OP_JEQ = 4'b1011;
  localparam logic [3:0] OP_JGE = 4'b1100;
  localparam logic [3:0] OP_JLE = 4'b1101;

  // flags is packed as {eq, gt, lt}
  function automatic logic cond_met(input logic [3:0] op, input logic [2:0] flags);
    cond_met = 1'b0;
    case (op)
      OP_JEQ:  cond_met = flags[2];
      OP_JGE:  cond_met = flags[2] | flags[1];
      OP_JLE:  cond_met = flags[2] | flags[0];
      default: cond_met = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/jump_lut.sv
// Jump-target register file: one synchronous write port, one combinational
// read port, all entries cleared on reset.
module jump_lut #(
  parameter int LUT_W = 2,
  parameter int PCW   = 10
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             we_i,
  input  logic [LUT_W-1:0] waddr_i,
  input  logic [PCW-1:0]   wdata_i,
  input  logic [LUT_W-1:0] raddr_i,
  output logic [PCW-1:0]   rdata_o
);

  localparam int DEPTH = 2 ** LUT_W;

  logic [PCW-1:0] entry_q [DEPTH];

  // Reads see the pre-write value when a write hits the same entry.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (srst) begin
          entry_q[gi] <= '0;
        end else if (we_i && (waddr_i == LUT_W'(gi))) begin
          entry_q[gi] <= wdata_i;
        end
      end
    end
  endgenerate

  assign rdata_o = entry_q[raddr_i];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch / program sequencer: PC, compare flags, LUT-resolved
// conditional jumps and the IDLE/RUN/DONE program handshake.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int IW       = 9,
  parameter int PCW      = 10,
  parameter int LUT_W    = 2,
  parameter int PROG_LEN = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  output logic [PCW-1:0]   imem_addr,
  input  logic [IW-1:0]    imem_data,
  output logic [3:0]       opcode,
  output logic [IW-5:0]    operand,
  output logic             instr_valid,
  input  logic             branch,
  input  logic             alu_eq,
  input  logic             alu_gt,
  input  logic             alu_lt,
  input  logic             lut_we,
  input  logic [LUT_W-1:0] lut_addr,
  input  logic [PCW-1:0]   lut_data,
  output logic             done,
  output logic [15:0]      cycle_count
);

  localparam logic [PCW-1:0] LAST_PC = PCW'(PROG_LEN - 1);
  localparam logic [PCW-1:0] PC_ONE  = PCW'(1);

  state_e         state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [2:0]     flags_q, flags_d;
  logic [15:0]    count_q, count_d;

  logic [PCW-1:0] target;
  logic           retire;
  logic           taken;
  logic           target_oob;

  jump_lut #(
    .LUT_W (LUT_W),
    .PCW   (PCW)
  ) u_jump_lut (
    .clk     (clk),
    .srst    (reset),
    .we_i    (lut_we),
    .waddr_i (lut_addr),
    .wdata_i (lut_data),
    .raddr_i (imem_data[LUT_W-1:0]),
    .rdata_o (target)
  );

  assign opcode      = imem_data[IW-1:IW-4];
  assign operand     = imem_data[IW-5:0];
  assign retire      = (state_q == RUN) && !stall;
  assign instr_valid = retire;
  // Condition uses the flags latched before this cycle, not this cycle's compare.
  assign taken       = retire && branch && cond_met(opcode, flags_q);
  assign target_oob  = (32'(target) >= PROG_LEN);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    count_d = count_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
          flags_d = '0;
          count_d = '0;
        end
      end
      RUN: begin
        if (count_q != 16'hFFFF) begin
          count_d = count_q + 16'd1;
        end
        if (retire) begin
          if (opcode == OP_CMP) begin
            flags_d = {alu_eq, alu_gt, alu_lt};
          end
          if (taken) begin
            if (target_oob) begin
              state_d = DONE;
            end else begin
              pc_d = target;
            end
          end else if (pc_q == LAST_PC) begin
            state_d = DONE;
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      flags_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign done        = (state_q == DONE);
  assign cycle_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a
// randomized run, all compared against a behavioural program model.
module tb_fetch_sequencer;

  localparam int IW       = 9;
  localparam int PCW      = 10;
  localparam int LUT_W    = 2;
  localparam int PROG_LEN = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             stall = 1'b0;
  logic [PCW-1:0]   imem_addr;
  logic [IW-1:0]    imem_data;
  logic [3:0]       opcode;
  logic [IW-5:0]    operand;
  logic             instr_valid;
  logic             branch;
  logic             alu_eq = 1'b0;
  logic             alu_gt = 1'b0;
  logic             alu_lt = 1'b0;
  logic             lut_we = 1'b0;
  logic [LUT_W-1:0] lut_addr = '0;
  logic [PCW-1:0]   lut_data = '0;
  logic             done;
  logic [15:0]      cycle_count;

  logic [IW-1:0] rom [1024];
  logic          br_extra = 1'b0;

  // Model of the program: state 0=idle 1=run 2=done
  int m_state = 0;
  int m_pc    = 0;
  int m_count = 0;
  bit m_eq = 0, m_gt = 0, m_lt = 0;
  int m_lut [4] = '{0, 0, 0, 0};

  int pass_cnt  = 0;
  int total_cnt = 0;

  function automatic logic is_jump(input logic [3:0] op);
    is_jump = (op == 4'b1011) || (op == 4'b1100) || (op == 4'b1101);
  endfunction

  function automatic logic [IW-1:0] mk(input logic [3:0] op, input int idx);
    mk = {op, 3'b000, 2'(idx)};
  endfunction

  assign imem_data = rom[imem_addr];
  assign branch    = is_jump(opcode) | br_extra;

  fetch_sequencer #(
    .IW       (IW),
    .PCW      (PCW),
    .LUT_W    (LUT_W),
    .PROG_LEN (PROG_LEN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .opcode      (opcode),
    .operand     (operand),
    .instr_valid (instr_valid),
    .branch      (branch),
    .alu_eq      (alu_eq),
    .alu_gt      (alu_gt),
    .alu_lt      (alu_lt),
    .lut_we      (lut_we),
    .lut_addr    (lut_addr),
    .lut_data    (lut_data),
    .done        (done),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  // Advance one clock: model computes the next program state from the
  // present inputs, the DUT takes the edge, then the model commits.
  task automatic tick();
    int ns, npc, ncount, op, idx, tgt;
    bit neq, ngt, nlt, br, tk;
    int nlut [4];
    ns = m_state; npc = m_pc; ncount = m_count;
    neq = m_eq; ngt = m_gt; nlt = m_lt;
    nlut = m_lut;
    op  = int'(rom[m_pc][8:5]);
    idx = int'(rom[m_pc][1:0]);
    br  = is_jump(rom[m_pc][8:5]) || br_extra;
    if (lut_we) nlut[lut_addr] = int'(lut_data);
    if (reset) begin
      ns = 0; npc = 0; ncount = 0; neq = 0; ngt = 0; nlt = 0;
      foreach (nlut[i]) nlut[i] = 0;
    end else if (m_state != 1) begin
      if (start) begin
        ns = 1; npc = 0; ncount = 0; neq = 0; ngt = 0; nlt = 0;
      end
    end else begin
      ncount = (m_count < 65535) ? m_count + 1 : 65535;
      if (!stall) begin
        tk = br && ((op == 11 && m_eq) || (op == 12 && (m_gt || m_eq)) ||
                    (op == 13 && (m_lt || m_eq)));
        if (op == 9) begin
          neq = alu_eq; ngt = alu_gt; nlt = alu_lt;
        end
        tgt = m_lut[idx];
        if (tk) begin
          if (tgt >= PROG_LEN) ns = 2;
          else npc = tgt;
        end else if (m_pc == PROG_LEN - 1) begin
          ns = 2;
        end else begin
          npc = m_pc + 1;
        end
      end
    end
    @(posedge clk);
    #1;
    m_state = ns; m_pc = npc; m_count = ncount;
    m_eq = neq; m_gt = ngt; m_lt = nlt;
    m_lut = nlut;
  endtask

  task automatic write_lut(input int idx, input int val);
    lut_we = 1'b1; lut_addr = LUT_W'(idx); lut_data = PCW'(val);
    tick();
    lut_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_prog();
    for (int n = 0; n < 40 && m_state == 1; n++) tick();
  endtask

  task automatic clear_rom();
    foreach (rom[i]) rom[i] = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1;
    lut_we = 1'b1; lut_addr = 2'd1; lut_data = 10'd5;
    tick();
    tick();
    reset = 1'b0; start = 1'b0; lut_we = 1'b0;
    #1;
    total_cnt++;
    if (imem_addr !== 10'd0) $display("FAIL reset_pc got %0d want 0", imem_addr); else pass_cnt++;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    total_cnt++;
    if (cycle_count !== 16'd0) $display("FAIL reset_count got %0d want 0", cycle_count); else pass_cnt++;
    total_cnt++;
    if (instr_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", instr_valid); else pass_cnt++;
    $display("test_reset: pc=%0d done=%b count=%0d", imem_addr, done, cycle_count);
  endtask

  task automatic test_straight();
    clear_rom();
    pulse_start();
    for (int k = 0; k < PROG_LEN; k++) begin
      total_cnt++;
      if (imem_addr !== PCW'(k) || instr_valid !== 1'b1)
        $display("FAIL straight_addr step=%0d got addr=%0d valid=%b want addr=%0d valid=1",
                 k, imem_addr, instr_valid, k);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (done !== 1'b1 || cycle_count !== 16'(PROG_LEN) || imem_addr !== PCW'(PROG_LEN - 1))
      $display("FAIL straight_end got done=%b count=%0d pc=%0d want done=1 count=%0d pc=%0d",
               done, cycle_count, imem_addr, PROG_LEN, PROG_LEN - 1);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b1 || cycle_count !== 16'(PROG_LEN))
      $display("FAIL straight_hold got done=%b count=%0d want done=1 count=%0d",
               done, cycle_count, PROG_LEN);
    else pass_cnt++;
    $display("test_straight: done=%b count=%0d", done, cycle_count);
  endtask

  task automatic test_cmp_jeq();
    int lutv [4] = '{2, 2, 3, 3};
    bit eqv  [4] = '{1, 0, 1, 0};
    int expv [4] = '{2, 2, 3, 2};
    clear_rom();
    rom[0] = mk(4'b1001, 0);
    rom[1] = mk(4'b1011, 1);
    for (int c = 0; c < 4; c++) begin
      write_lut(1, lutv[c]);
      alu_eq = eqv[c]; alu_gt = 1'b0; alu_lt = 1'b0;
      pulse_start();
      total_cnt++;
      if (imem_addr !== 10'd0) $display("FAIL jeq_pc0 case=%0d got %0d want 0", c, imem_addr); else pass_cnt++;
      tick();
      total_cnt++;
      if (imem_addr !== 10'd1) $display("FAIL jeq_pc1 case=%0d got %0d want 1", c, imem_addr); else pass_cnt++;
      tick();
      total_cnt++;
      if (imem_addr !== PCW'(expv[c]))
        $display("FAIL jeq_target case=%0d got %0d want %0d", c, imem_addr, expv[c]);
      else pass_cnt++;
      $display("test_cmp_jeq: case=%0d lut=%0d eq=%b next=%0d", c, lutv[c], eqv[c], imem_addr);
      finish_prog();
    end
  endtask

  task automatic test_jge_jle();
    logic [3:0] opv [4] = '{4'b1100, 4'b1101, 4'b1100, 4'b1101};
    int expv [4] = '{5, 2, 2, 5};
    clear_rom();
    rom[0] = mk(4'b1001, 0);
    write_lut(1, 5);
    for (int c = 0; c < 4; c++) begin
      rom[1] = mk(opv[c], 1);
      alu_eq = 1'b0; alu_gt = (c < 2); alu_lt = (c >= 2);
      pulse_start();
      tick();
      tick();
      total_cnt++;
      if (imem_addr !== PCW'(expv[c]))
        $display("FAIL jge_jle case=%0d got %0d want %0d", c, imem_addr, expv[c]);
      else pass_cnt++;
      $display("test_jge_jle: case=%0d op=%b next=%0d", c, opv[c], imem_addr);
      finish_prog();
    end
  endtask

  task automatic test_stall();
    clear_rom();
    rom[0] = mk(4'b1001, 0);
    rom[2] = mk(4'b1001, 0);
    rom[3] = mk(4'b1011, 1);
    write_lut(1, 6);
    alu_eq = 1'b1; alu_gt = 1'b0; alu_lt = 1'b0;
    pulse_start();
    tick();
    tick();
    stall = 1'b1;
    alu_eq = 1'b0; alu_gt = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      total_cnt++;
      if (instr_valid !== 1'b0) $display("FAIL stall_valid step=%0d got %b want 0", s, instr_valid); else pass_cnt++;
      tick();
      total_cnt++;
      if (imem_addr !== 10'd2) $display("FAIL stall_pc step=%0d got %0d want 2", s, imem_addr); else pass_cnt++;
    end
    total_cnt++;
    if (cycle_count !== 16'd5) $display("FAIL stall_count got %0d want 5", cycle_count); else pass_cnt++;
    stall = 1'b0;
    alu_eq = 1'b1; alu_gt = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (imem_addr !== 10'd6) $display("FAIL stall_jeq got %0d want 6", imem_addr); else pass_cnt++;
    $display("test_stall: pc=%0d count=%0d", imem_addr, cycle_count);
    finish_prog();
  endtask

  task automatic test_done_target();
    clear_rom();
    rom[0] = mk(4'b1001, 0);
    rom[1] = mk(4'b1011, 2);
    write_lut(2, 1023);
    alu_eq = 1'b1; alu_gt = 1'b0; alu_lt = 1'b0;
    pulse_start();
    tick();
    tick();
    total_cnt++;
    if (done !== 1'b1 || imem_addr !== 10'd1 || cycle_count !== 16'd2)
      $display("FAIL oob_done got done=%b pc=%0d count=%0d want done=1 pc=1 count=2",
               done, imem_addr, cycle_count);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b1 || imem_addr !== 10'd1)
      $display("FAIL oob_hold got done=%b pc=%0d want done=1 pc=1", done, imem_addr);
    else pass_cnt++;
    pulse_start();
    total_cnt++;
    if (done !== 1'b0 || imem_addr !== 10'd0 || cycle_count !== 16'd0)
      $display("FAIL restart got done=%b pc=%0d count=%0d want done=0 pc=0 count=0",
               done, imem_addr, cycle_count);
    else pass_cnt++;
    $display("test_done_target: restart pc=%0d done=%b", imem_addr, done);
    finish_prog();
  endtask

  task automatic test_lut_same_cycle();
    clear_rom();
    rom[0] = mk(4'b1001, 0);
    rom[1] = mk(4'b1011, 1);
    write_lut(1, 4);
    alu_eq = 1'b1; alu_gt = 1'b0; alu_lt = 1'b0;
    pulse_start();
    tick();
    lut_we = 1'b1; lut_addr = 2'd1; lut_data = 10'd6;
    tick();
    lut_we = 1'b0;
    total_cnt++;
    if (imem_addr !== 10'd4) $display("FAIL lut_old got %0d want 4", imem_addr); else pass_cnt++;
    finish_prog();
    pulse_start();
    tick();
    tick();
    total_cnt++;
    if (imem_addr !== 10'd6) $display("FAIL lut_new got %0d want 6", imem_addr); else pass_cnt++;
    $display("test_lut_same_cycle: second run target=%0d", imem_addr);
    finish_prog();
  endtask

  task automatic test_reset_midrun();
    clear_rom();
    rom[0] = mk(4'b1001, 0);
    rom[2] = mk(4'b1011, 1);
    write_lut(1, 5);
    alu_eq = 1'b1; alu_gt = 1'b0; alu_lt = 1'b0;
    pulse_start();
    tick();
    reset = 1'b1; start = 1'b1;
    lut_we = 1'b1; lut_addr = 2'd1; lut_data = 10'd7;
    tick();
    reset = 1'b0; start = 1'b0; lut_we = 1'b0;
    #1;
    total_cnt++;
    if (imem_addr !== 10'd0 || done !== 1'b0 || instr_valid !== 1'b0 || cycle_count !== 16'd0)
      $display("FAIL midrun_reset got pc=%0d done=%b valid=%b count=%0d want pc=0 done=0 valid=0 count=0",
               imem_addr, done, instr_valid, cycle_count);
    else pass_cnt++;
    pulse_start();
    tick();
    tick();
    tick();
    total_cnt++;
    if (imem_addr !== 10'd0 || cycle_count !== 16'd3)
      $display("FAIL lut_cleared got pc=%0d count=%0d want pc=0 count=3", imem_addr, cycle_count);
    else pass_cnt++;
    $display("test_reset_midrun: jump via cleared lut pc=%0d", imem_addr);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] ops [6] = '{4'b0000, 4'b1001, 4'b1011, 4'b1100, 4'b1101, 4'b0011};
    logic [IW-1:0] w;
    int errs = 0;
    clear_rom();
    for (int i = 0; i < PROG_LEN; i++) begin
      rom[i] = {ops[$urandom_range(0, 5)], 5'($urandom)};
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset    = ($urandom_range(0, 99) == 0);
      start    = ($urandom_range(0, 7) == 0);
      stall    = ($urandom_range(0, 4) == 0);
      alu_eq   = 1'($urandom); alu_gt = 1'($urandom); alu_lt = 1'($urandom);
      br_extra = ($urandom_range(0, 5) == 0);
      lut_we   = ($urandom_range(0, 9) == 0);
      lut_addr = LUT_W'($urandom);
      lut_data = ($urandom_range(0, 11) == 0) ? 10'd1023 : PCW'($urandom_range(0, 9));
      #1;
      w = rom[m_pc];
      total_cnt++;
      if (instr_valid !== (m_state == 1 && !stall) || opcode !== w[8:5] || operand !== w[4:0]) begin
        $display("FAIL rand_comb cyc=%0d got valid=%b op=%b opd=%b want valid=%b op=%b opd=%b",
                 cyc, instr_valid, opcode, operand, (m_state == 1 && !stall), w[8:5], w[4:0]);
        errs++;
      end else pass_cnt++;
      tick();
      total_cnt++;
      if (imem_addr !== PCW'(m_pc) || done !== (m_state == 2) || cycle_count !== 16'(m_count)) begin
        $display("FAIL rand_state cyc=%0d got pc=%0d done=%b count=%0d want pc=%0d done=%b count=%0d",
                 cyc, imem_addr, done, cycle_count, m_pc, (m_state == 2), m_count);
        errs++;
      end else pass_cnt++;
    end
    reset = 1'b0; start = 1'b0; stall = 1'b0; br_extra = 1'b0; lut_we = 1'b0;
    $display("test_random: 400 cycles, %0d mismatching cycles", errs);
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_straight();
    test_cmp_jeq();
    test_jge_jle();
    test_stall();
    test_done_target();
    test_lut_same_cycle();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch and program-sequencing unit that drives the control decoder's 4-bit opcode input and acts on its branch output. It holds the program counter, addresses the instruction ROM, latches compare flags, resolves conditional jumps through a writable jump look-up table and runs an IDLE/RUN/DONE program handshake with the testbench or top level. It sits between the instruction ROM and the control decoder in the single-cycle datapath.

## Interface
- `IW`, 9: instruction width; opcode = `instr[IW-1:IW-4]`, operand = `instr[IW-5:0]`
- `PCW`, 10: program-counter / ROM address width
- `LUT_W`, 2: jump-LUT index width (2^LUT_W entries); index = `instr[LUT_W-1:0]`
- `PROG_LEN`, 1024: number of valid instructions; the last is at `PROG_LEN-1`
- `clk` input 1: single clock, all state on rising edge
- `reset` input 1: synchronous, active-high
- `start` input 1: pulse to launch program execution
- `stall` input 1: hold the PC and suppress retirement this cycle
- `imem_addr` output PCW: ROM address, equal to the PC
- `imem_data` input IW: ROM word, combinational from `imem_addr`
- `opcode` output 4: to decoder `instr`; `imem_data[IW-1:IW-4]`
- `operand` output IW-4: `imem_data[IW-5:0]`
- `instr_valid` output 1: high in RUN when `stall`=0
- `branch` input 1: decoder Branch output for the current opcode
- `alu_eq`, `alu_gt`, `alu_lt` input 1 each: ALU compare results
- `lut_we` input 1, `lut_addr` input LUT_W, `lut_data` input PCW: jump-LUT write port
- `done` output 1: program finished
- `cycle_count` output 16: RUN cycles of the current or last program

## Operation
- States: IDLE, RUN, DONE. On reset: IDLE, PC=0, flags {eq,gt,lt}=0, all LUT entries 0, `done`=0, `cycle_count`=0.
- IDLE: on `start`, go to RUN with PC=0, flags cleared and `cycle_count`=0.
- DONE: `done`=1. On `start`, behave as in IDLE and drop `done`.
- RUN: ignores `start`.
- Retire means RUN with `stall`=0.
- On retire with opcode 1001 (compare): flags <= {alu_eq, alu_gt, alu_lt}.
- On retire with `branch`=1: the condition is selected by opcode:
  - 1011: taken if eq.
  - 1100: taken if gt|eq.
  - 1101: taken if lt|eq.
  - Any other opcode with `branch`=1: not taken.
- Branches use the flags registered before the current cycle.
- Next PC:
  - Taken branch: `lut[instr[LUT_W-1:0]]`.
  - Otherwise: PC+1.
- Go to DONE instead of updating the PC when either holds:
  - A non-taken instruction retires at PC=`PROG_LEN-1`.
  - A taken target is >= `PROG_LEN`.
- In DONE, the PC holds its last value.
- `cycle_count` increments every RUN cycle, including stalled cycles, and saturates at 0xFFFF.
- LUT write: when `lut_we`=1, `lut[lut_addr]` <= `lut_data`, accepted in any state. A branch reading the same entry in the same cycle uses the old value.
- `stall` outside RUN has no effect.

## Timing
- `opcode` and `operand` are combinational from `imem_data`. `instr_valid` is combinational from state and `stall`.
- A retire at edge t updates the PC; the new `imem_addr` is visible after edge t, giving a single-cycle fetch-to-execute path.
- `start` sampled at edge t means RUN begins and `imem_addr`=0 in cycle t+1.
- `done` rises the cycle after the final retire and is held until the next accepted `start` or `reset`.
- `reset` overrides everything, including mid-RUN, `start` and `lut_we` in the same cycle.

## Structure
- Package `fetch_pkg`:
  - State enum (`IDLE`, `RUN`, `DONE`).
  - Opcode constants `OP_CMP`=4'b1001, `OP_JEQ`=4'b1011, `OP_JGE`=4'b1100, `OP_JLE`=4'b1101.
  - These constants are shared with the control decoder.
- Sub-module `jump_lut`: a 2^LUT_W × PCW register file with one synchronous write port and one combinational read port, reset to 0. Everything else stays in `fetch_sequencer`.

## Test plan
- Straight line, PROG_LEN=4, no branches, `start` pulse: `imem_addr` 0,1,2,3; `done`=1 on the following cycle; `cycle_count`=4.
- Compare then JEQ:
  - Setup: LUT[1]=2; ROM[0]=CMP with eq=1; ROM[1]=JEQ with index 1.
  - Required: `imem_addr` sequence 0,1,2.
  - Repeat with eq=0: sequence 0,1,2 via fall-through. Then use LUT[1]=3 and require taken → 3, not-taken → 2.
- JGE/JLE: flags {0,1,0} give JGE taken and JLE not taken; flags {0,0,1} give the reverse.
- Stall for 3 cycles at PC=2: PC holds at 2, `instr_valid`=0, flags unchanged, `cycle_count` still increments by 3.
- Taken target 1023 with PROG_LEN=8 → DONE next cycle with PC unchanged. `start` in DONE → PC=0 and `done`=0.
- Boundary cases:
  - `lut_we` to entry 1 in the same cycle as a taken JEQ using entry 1: the old target is used.
  - `reset` mid-RUN: IDLE with PC=0 next cycle.
